// File: rtl/pdm_cic_decimator.sv
// pdm_cic_decimator
// Converts a 1-bit PDM stream into signed W-bit PCM samples using a 3-stage
// CIC decimator with ratio R = 2**R_LOG2. Full-scale density (all ones) maps
// to the positive full scale, and all zeros maps to the negative full scale.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   en         PDM bit-valid strobe; pdm_in is consumed on clk edges with en=1
//   pdm_in     PDM data bit
//   pcm_out    decimated signed PCM sample, held between updates
//   pcm_valid  one-cycle pulse when pcm_out updates
module pdm_cic_decimator #(
  parameter int W      = 16,
  parameter int R_LOG2 = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                pdm_in,
  output logic signed [W-1:0] pcm_out,
  output logic                pcm_valid
);

  localparam int B     = 3*R_LOG2 + 1;
  localparam int SHIFT = 3*R_LOG2 - W;

  // Midpoint of the comb output range; subtracting it centres the sample on 0.
  localparam logic [B-1:0]        MID    = B'(1) << (3*R_LOG2 - 1);
  localparam logic signed [B-1:0] SAT_HI = B'(2**(W-1) - 1);
  localparam logic signed [B-1:0] SAT_LO = ~SAT_HI;

  logic [B-1:0]        x;
  logic [B-1:0]        i1, i2, i3;
  logic [B-1:0]        d1, d2, d3;
  logic [B-1:0]        c1, c2, c3;
  logic [R_LOG2-1:0]   cnt;
  logic                dec_tick;
  logic [1:0]          warm;
  logic signed [B-1:0] s_full;
  logic signed [B-1:0] s_shift;
  logic signed [W-1:0] pcm_sat;

  assign x = {{(B-1){1'b0}}, pdm_in};

  // Combs read the registered I3 during the dec_tick cycle; the integrators
  // may already be taking the next frame's first bit in that same cycle.
  always_comb begin
    c1 = i3 - d1;
    c2 = c1 - d2;
    c3 = c2 - d3;
  end

  // Only the top end can exceed the W-bit range (C3 = 2**(3*R_LOG2)).
  always_comb begin
    s_full  = signed'(c3 - MID);
    s_shift = s_full >>> SHIFT;
    if (s_shift > SAT_HI)
      pcm_sat = SAT_HI[W-1:0];
    else if (s_shift < SAT_LO)
      pcm_sat = SAT_LO[W-1:0];
    else
      pcm_sat = s_shift[W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i1        <= '0;
      i2        <= '0;
      i3        <= '0;
      d1        <= '0;
      d2        <= '0;
      d3        <= '0;
      cnt       <= '0;
      dec_tick  <= 1'b0;
      warm      <= 2'd0;
      pcm_out   <= '0;
      pcm_valid <= 1'b0;
    end else begin
      pcm_valid <= 1'b0;
      dec_tick  <= 1'b0;

      if (en) begin
        // Parallel update from registered values; wrap modulo 2**B is intended.
        i1       <= i1 + x;
        i2       <= i2 + i1;
        i3       <= i3 + i2;
        cnt      <= cnt + 1'b1;
        dec_tick <= (cnt == '1);
      end

      if (dec_tick) begin
        d1 <= i3;
        d2 <= c1;
        d3 <= c2;
        // The first two frames still carry start-up transients in the combs.
        if (warm != 2'd2) begin
          warm <= warm + 2'd1;
        end else begin
          pcm_out   <= pcm_sat;
          pcm_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pdm_cic_decimator.sv
module tb_pdm_cic_decimator;

  localparam int W      = 16;
  localparam int R_LOG2 = 6;
  localparam int R      = 64;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                en = 1'b0;
  logic                pdm_in = 1'b0;
  logic signed [W-1:0] pcm_out;
  logic                pcm_valid;

  int errors = 0;
  int checks = 0;

  longint en_total = 0;
  longint cyc = 0;
  logic signed [W-1:0] v_val[$];
  longint              v_en[$];
  longint              v_cyc[$];

  pdm_cic_decimator #(.W(W), .R_LOG2(R_LOG2)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .pdm_in   (pdm_in),
    .pcm_out  (pcm_out),
    .pcm_valid(pcm_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (en && !reset) en_total <= en_total + 1;

  // Log every valid sample with the en count and cycle number at which it is seen.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (pcm_valid) begin
      v_val.push_back(pcm_out);
      v_en.push_back(en_total);
      v_cyc.push_back(cyc);
    end
  end

  function automatic logic pat_bit(input int kind, input int j);
    case (kind)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return (j % 2) == 0;
      default: return (j % 4) != 3;
    endcase
  endfunction

  // Reference CIC: unbounded integrators, output = third difference of the
  // integrator value taken at frame ends.
  function automatic logic signed [W-1:0] model_pcm(input logic bits[$], input int f);
    longint a1 = 0, a2 = 0, a3 = 0, t2, t3;
    longint y[4];
    longint c3, s, v;
    for (int k = 0; k < 4; k++) y[k] = 0;
    for (int n = 1; n <= f*R; n++) begin
      t3 = a3 + a2;
      t2 = a2 + a1;
      a1 = a1 + (bits[n-1] ? 1 : 0);
      a2 = t2;
      a3 = t3;
      if ((n % R) == 0 && (n / R) >= f - 3) y[n/R - (f-3)] = a3;
    end
    c3 = y[3] - 3*y[2] + 3*y[1] - y[0];
    s  = c3 - (longint'(1) << (3*R_LOG2 - 1));
    v  = s >>> (3*R_LOG2 - W);
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return W'(v);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    en = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      en = 1'b0;
    end
  endtask

  task automatic stream(input int n, input int kind, input int gap);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      en = 1'b1;
      pdm_in = pat_bit(kind, j);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        en = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (pcm_out !== 16'sd0) begin
      errors++;
      $display("FAIL reset_pcm_out: got %0d want 0", pcm_out);
    end
    checks++;
    if (pcm_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_pcm_valid: got %b want 0", pcm_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    idle(3);
    checks++;
    if (pcm_out !== 16'sd0 || pcm_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got out=%0d valid=%b want 0/0", pcm_out, pcm_valid);
    end
  endtask

  task automatic test_zeros();
    int base;
    longint e0;
    logic signed [W-1:0] want;
    want = -16'sd32768;
    do_reset();
    base = v_val.size();
    e0 = en_total;
    stream(192 + 3*R + 10, 0, 0);
    idle(4);
    checks++;
    if (v_val.size() - base !== 4) begin
      errors++;
      $display("FAIL zeros_count: got %0d want 4", v_val.size() - base);
    end
    for (int i = 0; i < 4 && base + i < v_val.size(); i++) begin
      checks++;
      if (v_val[base+i] !== want) begin
        errors++;
        $display("FAIL zeros_value[%0d]: got %0d want %0d", i, v_val[base+i], want);
      end
      checks++;
      if (v_en[base+i] - e0 !== longint'(193 + R*i)) begin
        errors++;
        $display("FAIL zeros_en_pos[%0d]: got %0d want %0d", i, v_en[base+i] - e0, 193 + R*i);
      end
    end
  endtask

  task automatic test_ones_long();
    int base, bad, n;
    do_reset();
    base = v_val.size();
    stream(20000, 1, 0);
    idle(4);
    n = v_val.size() - base;
    checks++;
    if (n !== 310) begin
      errors++;
      $display("FAIL ones_count: got %0d want 310", n);
    end
    checks++;
    if (n > 0 && v_val[base] !== 16'sd32767) begin
      errors++;
      $display("FAIL ones_first: got %0d want 32767", v_val[base]);
    end
    bad = 0;
    for (int i = 0; i < n; i++)
      if (v_val[base+i] !== 16'sd32767) bad++;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL ones_wrap: got %0d samples not 32767 want 0", bad);
    end
  endtask

  task automatic test_pattern(input int kind, input logic signed [W-1:0] want);
    int base;
    do_reset();
    base = v_val.size();
    stream(5*R, kind, 0);
    idle(4);
    checks++;
    if (v_val.size() - base !== 3) begin
      errors++;
      $display("FAIL pattern%0d_count: got %0d want 3", kind, v_val.size() - base);
    end
    for (int i = 0; i < 3 && base + i < v_val.size(); i++) begin
      checks++;
      if (v_val[base+i] !== want) begin
        errors++;
        $display("FAIL pattern%0d_value[%0d]: got %0d want %0d", kind, i, v_val[base+i], want);
      end
    end
  endtask

  task automatic test_gapped();
    int base;
    longint e0;
    do_reset();
    base = v_val.size();
    e0 = en_total;
    stream(5*R, 1, 3);
    idle(4);
    checks++;
    if (v_val.size() - base !== 3) begin
      errors++;
      $display("FAIL gapped_count: got %0d want 3", v_val.size() - base);
    end
    for (int i = 0; i < 3 && base + i < v_val.size(); i++) begin
      checks++;
      if (v_val[base+i] !== 16'sd32767) begin
        errors++;
        $display("FAIL gapped_value[%0d]: got %0d want 32767", i, v_val[base+i]);
      end
    end
    if (v_val.size() - base >= 1) begin
      checks++;
      if (v_en[base] - e0 !== 192) begin
        errors++;
        $display("FAIL gapped_en_pos: got %0d want 192", v_en[base] - e0);
      end
    end
    for (int i = 1; i < 3 && base + i < v_val.size(); i++) begin
      checks++;
      if (v_cyc[base+i] - v_cyc[base+i-1] !== 256) begin
        errors++;
        $display("FAIL gapped_period[%0d]: got %0d want 256", i, v_cyc[base+i] - v_cyc[base+i-1]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    int base;
    longint e0;
    do_reset();
    stream(193, 0, 0);
    @(posedge clk);
    #2;
    checks++;
    if (pcm_valid !== 1'b1 || pcm_out !== -16'sd32768) begin
      errors++;
      $display("FAIL midreset_pre: got out=%0d valid=%b want -32768/1", pcm_out, pcm_valid);
    end
    en = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (pcm_out !== 16'sd0 || pcm_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async: got out=%0d valid=%b want 0/0", pcm_out, pcm_valid);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    base = v_val.size();
    e0 = en_total;
    stream(192 + 10, 1, 0);
    idle(4);
    checks++;
    if (v_val.size() - base !== 1) begin
      errors++;
      $display("FAIL midreset_count: got %0d want 1", v_val.size() - base);
    end
    if (v_val.size() - base >= 1) begin
      checks++;
      if (v_en[base] - e0 !== 193) begin
        errors++;
        $display("FAIL midreset_en_pos: got %0d want 193", v_en[base] - e0);
      end
      checks++;
      if (v_val[base] !== 16'sd32767) begin
        errors++;
        $display("FAIL midreset_value: got %0d want 32767", v_val[base]);
      end
    end
  endtask

  task automatic test_step();
    int base;
    logic bq[$];
    logic signed [W-1:0] want;
    do_reset();
    for (int j = 0; j < 4*R; j++) bq.push_back(1'b0);
    for (int j = 0; j < 5*R; j++) bq.push_back(1'b1);
    base = v_val.size();
    for (int j = 0; j < bq.size(); j++) begin
      @(negedge clk);
      en = 1'b1;
      pdm_in = bq[j];
    end
    idle(5);
    checks++;
    if (v_val.size() - base !== 7) begin
      errors++;
      $display("FAIL step_count: got %0d want 7", v_val.size() - base);
    end
    for (int i = 0; i < 7 && base + i < v_val.size(); i++) begin
      want = model_pcm(bq, i + 3);
      checks++;
      if (v_val[base+i] !== want) begin
        errors++;
        $display("FAIL step_frame%0d: got %0d want %0d", i + 3, v_val[base+i], want);
      end
      if (i > 0) begin
        checks++;
        if (v_val[base+i] < v_val[base+i-1]) begin
          errors++;
          $display("FAIL step_monotonic[%0d]: got %0d after %0d want non-decreasing", i, v_val[base+i], v_val[base+i-1]);
        end
      end
    end
    if (v_val.size() - base >= 5) begin
      checks++;
      if (v_val[base+4] !== 16'sd32767) begin
        errors++;
        $display("FAIL step_settle: got %0d want 32767", v_val[base+4]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zeros();
    test_pattern(2, 16'sd0);
    test_pattern(3, 16'sd16384);
    test_gapped();
    test_reset_midstream();
    test_step();
    test_ones_long();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
